// File: rtl/serial_tx_ctrl_if.sv
// Sample handshake plus shift-register strobe bundle between serial_tx_ctrl and its neighbours.
// master drives samples in and observes the serial-path outputs; slave is the controller side.
interface serial_tx_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             i_valid;
   logic [WIDTH-1:0] i_data;
   logic             o_ready;
   logic             o_load;
   logic [WIDTH-1:0] o_ldata;
   logic             o_shift;
   logic             o_sclk;
   logic             o_cs_n;
   logic             o_busy;
   logic             o_done;

   modport master (
      output i_valid, i_data,
      input  o_ready, o_load, o_ldata, o_shift, o_sclk, o_cs_n, o_busy, o_done
   );

   modport slave (
      input  i_valid, i_data,
      output o_ready, o_load, o_ldata, o_shift, o_sclk, o_cs_n, o_busy, o_done
   );
endinterface

// File: rtl/serial_tx_ctrl.sv
// Load/shift sequencer for the serial DAC/codec output shift register, MSB first.
// Define SERIAL_TX_CTRL_CONT_EN to allow back-to-back frames with no chip-select gap.
//
// state | meaning
// IDLE  | waiting for a sample, o_ready high
// LOAD  | one-cycle parallel load strobe, frame select asserted
// SHIFT | WIDTH bit periods of 2*CLK_DIV cycles, shift strobe at the start of each
// GAP   | frame select released for GAP_CYCLES, o_done on the first cycle
module serial_tx_ctrl #(
   parameter int WIDTH      = 8,
   parameter int CLK_DIV    = 2,
   parameter int GAP_CYCLES = 2
) (
   input  logic           i_clk,
   input  logic           i_rst,
   serial_tx_ctrl_if.slave bus
);
   localparam int DIV_N = 2 * CLK_DIV;
   localparam int DW    = $clog2(DIV_N);
   localparam int BW    = $clog2(WIDTH);
   localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV_N - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

   state_t           state_q, state_d;
   logic [DW-1:0]    div_cnt_q, div_cnt_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
   logic [WIDTH-1:0] ldata_q, ldata_d;
   logic             ready_q, ready_d;
   logic             load_q, load_d;
   logic             shift_q, shift_d;
   logic             sclk_q, sclk_d;
   logic             cs_n_q, cs_n_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             handshake;

   assign handshake = bus.i_valid & ready_q;

   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      ldata_d   = ldata_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (handshake) begin
               ldata_d = bus.i_data;
               state_d = LOAD;
            end
         end
         LOAD: begin
            state_d   = SHIFT;
            div_cnt_d = '0;
            bit_cnt_d = '0;
         end
         SHIFT: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               if (bit_cnt_q == BIT_LAST) begin
                  done_d    = 1'b1;
`ifdef SERIAL_TX_CTRL_CONT_EN
                  if (handshake) begin
                     ldata_d = bus.i_data;
                     state_d = LOAD;
                  end else begin
                     gap_cnt_d = GAP_LAST;
                     state_d   = GAP;
                  end
`else
                  gap_cnt_d = GAP_LAST;
                  state_d   = GAP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end else begin
               div_cnt_d = div_cnt_q + DW'(1);
            end
         end
         GAP: begin
            if (gap_cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every output flop lines up with its state.
   always_comb begin
      ready_d = (state_d == IDLE);
`ifdef SERIAL_TX_CTRL_CONT_EN
      if (state_d == SHIFT && div_cnt_d == DIV_LAST && bit_cnt_d == BIT_LAST) begin
         ready_d = 1'b1;
      end
`else
      ready_d = ready_d | 1'b0;
`endif
      load_d  = (state_d == LOAD);
      shift_d = (state_d == SHIFT) && (div_cnt_d == '0);
      sclk_d  = (state_d == SHIFT) && (div_cnt_d >= DIV_HALF);
      cs_n_d  = !((state_d == LOAD) || (state_d == SHIFT));
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         ldata_q   <= '0;
         ready_q   <= 1'b1;
         load_q    <= 1'b0;
         shift_q   <= 1'b0;
         sclk_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         ldata_q   <= ldata_d;
         ready_q   <= ready_d;
         load_q    <= load_d;
         shift_q   <= shift_d;
         sclk_q    <= sclk_d;
         cs_n_q    <= cs_n_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.o_ready = ready_q;
   assign bus.o_load  = load_q;
   assign bus.o_ldata = ldata_q;
   assign bus.o_shift = shift_q;
   assign bus.o_sclk  = sclk_q;
   assign bus.o_cs_n  = cs_n_q;
   assign bus.o_busy  = busy_q;
   assign bus.o_done  = done_q;
endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Bench for serial_tx_ctrl: cycle-accurate frame-timeline model, serial bit scoreboard,
// directed scenarios and randomized traffic; a second 12-bit / CLK_DIV=3 instance for timing.
`timescale 1ns/1ps
module tb_serial_tx_ctrl;
   localparam int W   = 8;
   localparam int CD  = 2;
   localparam int GAP = 2;
   localparam int L   = 2 * CD * W;
   localparam int W2  = 12;
`ifdef SERIAL_TX_CTRL_CONT_EN
   localparam bit CONT = 1'b1;
`else
   localparam bit CONT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   serial_tx_ctrl_if #(.WIDTH(W))  bus  ();
   serial_tx_ctrl_if #(.WIDTH(W2)) bus2 ();

   serial_tx_ctrl #(.WIDTH(W), .CLK_DIV(CD), .GAP_CYCLES(GAP)) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus)
   );
   serial_tx_ctrl #(.WIDTH(W2), .CLK_DIV(3), .GAP_CYCLES(2)) dut2 (
      .i_clk(clk), .i_rst(rst), .bus(bus2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Downstream parallel-load shift registers; carry-out is the serial data line.
   logic [W-1:0]  sr = '0;
   logic          cout = 1'b0;
   logic [W2-1:0] sr2 = '0;
   logic          cout2 = 1'b0;
   always @(posedge clk) begin
      if (bus.o_load) sr <= bus.o_ldata;
      else if (bus.o_shift) begin
         cout <= sr[W-1];
         sr   <= sr << 1;
      end
      if (bus2.o_load) sr2 <= bus2.o_ldata;
      else if (bus2.o_shift) begin
         cout2 <= sr2[W2-1];
         sr2   <= sr2 << 1;
      end
   end

   // Model: k counts cycles since the LOAD cycle of the current frame, -1 when idle.
   int           k = -1;
   bit           done_flag = 1'b0;
   bit           chk_en = 1'b0;
   logic [W-1:0] exp_ldata = '0;
   logic         prev_sclk = 1'b0;
   bit           bitq[$];
   int m_load = 0, m_shift = 0, m_done = 0, m_rise = 0, m_cs_low = 0;
   int m_ready_low = 0, m_cs_run = 0, m_cs_max = 0, m_sclk_tog = 0;
   logic [31:0] rx_word = '0;

   always @(negedge clk) begin
      int   j;
      logic e_ready, e_load, e_shift, e_sclk, e_cs_n, e_busy, e_done;
      bit   hs;
      j       = k - 1;
      e_ready = (k < 0) || (CONT && k == L);
      e_load  = (k == 0);
      e_shift = (k >= 1) && (k <= L) && (j % (2 * CD) == 0);
      e_sclk  = (k >= 1) && (k <= L) && (j % (2 * CD) >= CD);
      e_cs_n  = !((k >= 0) && (k <= L));
      e_busy  = (k >= 0);
      e_done  = (k == L + 1) || (k == 0 && done_flag);
      if (chk_en) begin
         chk("ready", bus.o_ready, e_ready);
         chk("load",  bus.o_load,  e_load);
         chk("shift", bus.o_shift, e_shift);
         chk("sclk",  bus.o_sclk,  e_sclk);
         chk("cs_n",  bus.o_cs_n,  e_cs_n);
         chk("busy",  bus.o_busy,  e_busy);
         chk("done",  bus.o_done,  e_done);
         chk("ldata", bus.o_ldata, exp_ldata);
         if (bus.o_sclk === 1'b1 && prev_sclk === 1'b0) begin
            m_rise++;
            rx_word = {rx_word[30:0], cout};
            if (bitq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL serial_bit: sclk rise with no bit pending (cycle %0d)", cyc);
            end else begin
               chk("serial_bit", cout, bitq.pop_front());
            end
         end
         if (bus.o_sclk !== prev_sclk) m_sclk_tog++;
         if (bus.o_load)   m_load++;
         if (bus.o_shift)  m_shift++;
         if (bus.o_done)   m_done++;
         if (!bus.o_ready) m_ready_low++;
         if (!bus.o_cs_n) begin
            m_cs_low++;
            m_cs_run++;
            if (m_cs_run > m_cs_max) m_cs_max = m_cs_run;
         end else begin
            m_cs_run = 0;
         end
      end
      prev_sclk = bus.o_sclk;
      if (rst) begin
         k         = -1;
         done_flag = 1'b0;
         exp_ldata = '0;
         bitq.delete();
         chk_en    = 1'b1;
      end else begin
         hs        = bus.i_valid && e_ready;
         done_flag = 1'b0;
         if (hs) begin
            done_flag = (k == L);
            k         = 0;
            exp_ldata = bus.i_data;
            for (int b = W - 1; b >= 0; b--) bitq.push_back(bus.i_data[b]);
         end else if (k >= 0) begin
            k++;
            if (k > L + GAP) k = -1;
         end
      end
   end

   int          m2_rise = 0, m2_cs_low = 0;
   logic [31:0] rx2 = '0;
   int          rise2_cyc[$];
   logic        prev_sclk2 = 1'b0;
   always @(negedge clk) begin
      if (bus2.o_sclk === 1'b1 && prev_sclk2 === 1'b0) begin
         m2_rise++;
         rx2 = {rx2[30:0], cout2};
         rise2_cyc.push_back(cyc);
      end
      if (bus2.o_cs_n === 1'b0) m2_cs_low++;
      prev_sclk2 = bus2.o_sclk;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr_mon();
      m_load = 0; m_shift = 0; m_done = 0; m_rise = 0; m_cs_low = 0;
      m_ready_low = 0; m_cs_run = 0; m_cs_max = 0; m_sclk_tog = 0;
      rx_word = '0;
   endtask

   task automatic wait_hs(input string name, output int c);
      c = -1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (bus.o_ready === 1'b1 && bus.i_valid) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) begin
         checks++;
         errors++;
         $display("FAIL %s: no handshake within 200 cycles", name);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs1, hs2, c2;
      bus.i_valid  = 1'b0;
      bus.i_data   = '0;
      bus2.i_valid = 1'b0;
      bus2.i_data  = '0;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", bus.o_ready, 1);
      chk("rst_cs_n",  bus.o_cs_n,  1);
      chk("rst_busy",  bus.o_busy,  0);
      chk("rst_sclk",  bus.o_sclk,  0);
      chk("rst_load",  bus.o_load,  0);
      chk("rst_ldata", bus.o_ldata, 0);
      tick(1);

      // Single frame 0xA5
      clr_mon();
      bus.i_valid = 1'b1;
      bus.i_data  = 8'hA5;
      wait_hs("a5_hs", hs1);
      bus.i_valid = 1'b0;
      tick(45);
      chk("a5_rises",     m_rise, 8);
      chk("a5_bits",      rx_word[7:0], 8'hA5);
      chk("a5_cs_low",    m_cs_low, 33);
      chk("a5_loads",     m_load, 1);
      chk("a5_shifts",    m_shift, 8);
      chk("a5_done",      m_done, 1);
      chk("a5_ready_low", m_ready_low, CONT ? 34 : 35);

      // Back-pressure: valid held high across two samples
      clr_mon();
      bus.i_valid = 1'b1;
      bus.i_data  = 8'h3C;
      wait_hs("bp_hs1", hs1);
      bus.i_data  = 8'hC3;
      wait_hs("bp_hs2", hs2);
      bus.i_valid = 1'b0;
      chk("bp_spacing", hs2 - hs1, CONT ? 33 : 36);
      tick(45);
      chk("bp_bits",  rx_word[15:0], 16'h3CC3);
      chk("bp_rises", m_rise, 16);
      chk("bp_loads", m_load, 2);

      // Reset during bit 3 of 0xFF
      clr_mon();
      bus.i_valid = 1'b1;
      bus.i_data  = 8'hFF;
      wait_hs("rst_hs", hs1);
      bus.i_valid = 1'b0;
      tick(14);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_cs_n",  bus.o_cs_n,  1);
      chk("midrst_sclk",  bus.o_sclk,  0);
      chk("midrst_ready", bus.o_ready, 1);
      chk("midrst_busy",  bus.o_busy,  0);
      chk("midrst_done",  bus.o_done,  0);
      tick(5);
      chk("midrst_no_done", m_done, 0);
      clr_mon();
      bus.i_valid = 1'b1;
      bus.i_data  = 8'h81;
      wait_hs("post_rst_hs", hs1);
      bus.i_valid = 1'b0;
      tick(45);
      chk("post_rst_bits",  rx_word[7:0], 8'h81);
      chk("post_rst_rises", m_rise, 8);

      // Idle stability
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      clr_mon();
      tick(100);
      chk("idle_loads",    m_load, 0);
      chk("idle_shifts",   m_shift, 0);
      chk("idle_sclk_tog", m_sclk_tog, 0);
      chk("idle_cs_low",   m_cs_low, 0);

      // Back-to-back 0xFF then 0x00
      clr_mon();
      bus.i_valid = 1'b1;
      bus.i_data  = 8'hFF;
      wait_hs("b2b_hs1", hs1);
      bus.i_data  = 8'h00;
      wait_hs("b2b_hs2", hs2);
      bus.i_valid = 1'b0;
      tick(45);
      chk("b2b_cs_run", m_cs_max, CONT ? 66 : 33);
      chk("b2b_done",   m_done, 2);
      chk("b2b_bits",   rx_word[15:0], 16'hFF00);

      // 12-bit, CLK_DIV=3 instance
      m2_rise = 0;
      m2_cs_low = 0;
      rx2 = '0;
      rise2_cyc.delete();
      bus2.i_valid = 1'b1;
      bus2.i_data  = 12'h9A5;
      c2 = -1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (bus2.o_ready === 1'b1) begin
            c2 = cyc;
            break;
         end
      end
      if (c2 < 0) begin
         checks++;
         errors++;
         $display("FAIL w12_hs: no handshake within 200 cycles");
      end
      tick(1);
      bus2.i_valid = 1'b0;
      tick(90);
      chk("w12_rises",  m2_rise, 12);
      chk("w12_bits",   rx2[11:0], 12'h9A5);
      chk("w12_cs_low", m2_cs_low, 73);
      for (int i = 1; i < rise2_cyc.size(); i++) begin
         chk("w12_spacing", rise2_cyc[i] - rise2_cyc[i-1], 6);
      end

      // Randomized traffic against the model
      repeat (1500) begin
         rst         = ($urandom_range(0, 299) == 0);
         bus.i_valid = ($urandom_range(0, 2) == 0);
         bus.i_data  = W'($urandom);
         tick(1);
      end
      rst = 1'b0;
      bus.i_valid = 1'b0;
      tick(50);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
